mmio_unit: RTL and testbench
============================

MMIO_UNIT -- requirements
Module: mmio_unit

Interface
REQ-001 Parameter LED_ADDR, default 9'h100, LED output register address.
REQ-002 Parameter HEX_ADDR, default 9'h120, 16-bit hex-display register address.
REQ-003 Parameter SW_ADDR, default 9'h140, switch input address (read-only).
REQ-004 Parameter TMR_BASE, default 9'h160, timer block base address; CTRL at +0, CMP at +1, CNT at +2.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mem_cmd  input  2  CPU bus command: 2'b00 none, 2'b01 read, 2'b10 write.
REQ-008 mem_addr  input  9  CPU bus address; bit 8 = 1 selects I/O space.
REQ-009 wdata  input  16  CPU write data.
REQ-010 sw  input  8  board switches SW[7:0].
REQ-011 rdata  output  16  registered I/O read data.
REQ-012 rvalid  output  1  high exactly one cycle after an accepted I/O read; top-level mux selects rdata when high.
REQ-013 ledr  output  8  LED register contents.
REQ-014 hex0, hex1, hex2, hex3  output  7 each  active-low segments of HEX register nibbles [3:0]..[15:12].
REQ-015 timer_flag  output  1  sticky timer-match flag.

Function
REQ-016 Access accepted only when mem_addr equals a mapped address; mem_addr[8]=0 or unmapped I/O addresses SHALL change no state and give rvalid=0.
REQ-017 Write to LED_ADDR SHALL load wdata[7:0] into ledr on that edge; read returns {8'b0, ledr}.
REQ-018 Write to HEX_ADDR SHALL load all 16 bits; read returns the register; hex outputs are combinational decode of the register, 0..F glyphs.
REQ-019 Read of SW_ADDR SHALL return {8'b0, sw} sampled on the accepting edge.
REQ-020 Read latency SHALL be one cycle: request at edge N, rdata/rvalid valid after edge N+1 (matches RAM dout timing); rdata holds its value while rvalid=0.
REQ-021 CTRL write: bit0 -> enable; bit1=1 clears count to 0; bit2=1 clears timer_flag; CTRL read returns {14'b0, timer_flag, enable}.
REQ-022 CMP write loads 16-bit compare value; CMP read returns it; CNT is read-only, writes ignored.
REQ-023 Timer FSM states IDLE (enable=0, count held) and RUN (enable=1); IDLE->RUN on CTRL write with bit0=1, RUN->IDLE on CTRL write with bit0=0.
REQ-024 In RUN with cmp!=0: if count==cmp then count<=0 and timer_flag<=1, else count<=count+1 (16-bit, wraps 0xFFFF->0).
REQ-025 In RUN with cmp==0: count SHALL hold and no flag is set.
REQ-026 CMP written below current count: counting SHALL continue through wrap until equality.
REQ-027 Same-edge flag set and flag clear: set SHALL win; same-edge match and count-clear: count becomes 0 and flag sets.
REQ-028 Read of CNT SHALL return count value before the accepting edge's update.

Reset
REQ-029 On reset: ledr=0, HEX reg=0 (hex0..3 show "0"), enable=0 (IDLE), cmp=0, count=0, timer_flag=0, rdata=0, rvalid=0.
REQ-030 Reset SHALL override any same-cycle access; a read accepted in the cycle before reset SHALL not produce rvalid after reset.

Structure
REQ-031 Shared package SHALL hold MNONE/MREAD/MWRITE encodings, default I/O addresses, CTRL bit positions.
REQ-032 Timer (FSM, count, cmp, flag) SHALL be sub-module io_timer; hex decode SHALL reuse existing sseg, four instances.

Verification
REQ-033 Reset, then write 16'h00A5 to 9'h100 -> ledr=8'hA5 next edge; read 9'h100 -> rvalid one cycle later, rdata=16'h00A5.
REQ-034 Write 16'h1F3C to 9'h120 -> hex3..hex0 = 1, F, 3, C glyphs; write to 9'h000 -> no I/O change, rvalid stays 0.
REQ-035 sw=8'h5A, read 9'h140 -> rdata=16'h005A, rvalid high exactly one cycle; read 9'h1FF -> rvalid=0.
REQ-036 cmp=3, CTRL=1 -> count 0,1,2,3,0; timer_flag rises on 3->0 edge; CTRL=16'h0005 -> flag cleared, timer keeps running.
REQ-037 Flag-clear write on the match edge -> timer_flag=1; reset asserted mid-RUN -> all outputs at reset values next edge.

Source files
------------

// File: rtl/mmio_unit_pkg.sv
// Shared definitions for the memory-mapped I/O unit: bus command encodings,
// default I/O addresses, timer control bit positions and timer state codes.
package mmio_unit_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] DEF_LED_ADDR = 9'h100;
  localparam logic [8:0] DEF_HEX_ADDR = 9'h120;
  localparam logic [8:0] DEF_SW_ADDR  = 9'h140;
  localparam logic [8:0] DEF_TMR_BASE = 9'h160;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_CLR_CNT  = 1;
  localparam int CTRL_CLR_FLAG = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/io_timer.sv
// Compare-match timer: IDLE/RUN FSM, 16-bit count, compare register and a
// sticky match flag. Register writes arrive already decoded from the bus.
module io_timer
  import mmio_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_we,
  input  logic        cmp_we,
  input  logic [15:0] wdata,
  output logic        enable,
  output logic [15:0] cmp,
  output logic [15:0] count,
  output logic        timer_flag
);

  logic [0:0]  state, state_next;
  logic [15:0] count_next, cmp_next;
  logic        flag_next;
  logic        counting, match;

  assign enable   = (state == ST_RUN);
  assign counting = enable && (cmp != '0);
  assign match    = counting && (count == cmp);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    cmp_next   = cmp;
    flag_next  = timer_flag;

    if (ctrl_we) state_next = wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
    if (cmp_we)  cmp_next   = wdata;

    // A match or an explicit clear both land on zero; otherwise advance.
    if (match || (ctrl_we && wdata[CTRL_CLR_CNT])) count_next = '0;
    else if (counting)                             count_next = count + 16'd1;

    // Setting the flag beats a simultaneous clear request.
    if (match)                                  flag_next = 1'b1;
    else if (ctrl_we && wdata[CTRL_CLR_FLAG])   flag_next = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      cmp        <= '0;
      timer_flag <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      cmp        <= cmp_next;
      timer_flag <= flag_next;
    end
  end

endmodule

// File: rtl/sseg.sv
// Hex nibble to active-low seven-segment decoder; seg[6:0] = {g,f,e,d,c,b,a}.
module sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/mmio_unit.sv
// Memory-mapped I/O block: LED and hex-display registers, switch input and a
// compare-match timer, with a one-cycle registered read path.
module mmio_unit
  import mmio_unit_pkg::*;
#(
  parameter logic [8:0] LED_ADDR = DEF_LED_ADDR,
  parameter logic [8:0] HEX_ADDR = DEF_HEX_ADDR,
  parameter logic [8:0] SW_ADDR  = DEF_SW_ADDR,
  parameter logic [8:0] TMR_BASE = DEF_TMR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] wdata,
  input  logic [7:0]  sw,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic [7:0]  ledr,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        timer_flag
);

  localparam logic [8:0] CTRL_ADDR = TMR_BASE;
  localparam logic [8:0] CMP_ADDR  = TMR_BASE + 9'd1;
  localparam logic [8:0] CNT_ADDR  = TMR_BASE + 9'd2;

  logic        is_rd, is_wr;
  logic        hit_led, hit_hex, hit_sw, hit_ctrl, hit_cmp, hit_cnt;
  logic        read_hit;
  logic [15:0] rd_mux;
  logic [15:0] hex_reg;
  logic        tmr_enable;
  logic [15:0] tmr_cmp, tmr_count;

  assign is_rd = (mem_cmd == MREAD);
  assign is_wr = (mem_cmd == MWRITE);

  // Only exact matches inside I/O space (bit 8 set) are decoded.
  assign hit_led  = mem_addr[8] && (mem_addr == LED_ADDR);
  assign hit_hex  = mem_addr[8] && (mem_addr == HEX_ADDR);
  assign hit_sw   = mem_addr[8] && (mem_addr == SW_ADDR);
  assign hit_ctrl = mem_addr[8] && (mem_addr == CTRL_ADDR);
  assign hit_cmp  = mem_addr[8] && (mem_addr == CMP_ADDR);
  assign hit_cnt  = mem_addr[8] && (mem_addr == CNT_ADDR);

  assign read_hit = is_rd && (hit_led || hit_hex || hit_sw ||
                              hit_ctrl || hit_cmp || hit_cnt);

  always_comb begin
    rd_mux = '0;
    if (hit_led)  rd_mux = {8'b0, ledr};
    if (hit_hex)  rd_mux = hex_reg;
    if (hit_sw)   rd_mux = {8'b0, sw};
    if (hit_ctrl) rd_mux = {14'b0, timer_flag, tmr_enable};
    if (hit_cmp)  rd_mux = tmr_cmp;
    if (hit_cnt)  rd_mux = tmr_count;
  end

  // NOTE: rdata is reset as well as rvalid; it has to hold a defined value
  // between reads, so leaving it unknown after reset is not an option.
  always_ff @(posedge clk) begin
    if (reset) begin
      ledr    <= '0;
      hex_reg <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      if (is_wr && hit_led) ledr    <= wdata[7:0];
      if (is_wr && hit_hex) hex_reg <= wdata;
      if (read_hit)         rdata   <= rd_mux;
      rvalid <= read_hit;
    end
  end

  io_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .ctrl_we    (is_wr && hit_ctrl),
    .cmp_we     (is_wr && hit_cmp),
    .wdata      (wdata),
    .enable     (tmr_enable),
    .cmp        (tmr_cmp),
    .count      (tmr_count),
    .timer_flag (timer_flag)
  );

  sseg u_sseg0 (.hex(hex_reg[3:0]),   .seg(hex0));
  sseg u_sseg1 (.hex(hex_reg[7:4]),   .seg(hex1));
  sseg u_sseg2 (.hex(hex_reg[11:8]),  .seg(hex2));
  sseg u_sseg3 (.hex(hex_reg[15:12]), .seg(hex3));

endmodule

// File: tb/tb_mmio_unit.sv
// Scoreboard bench for mmio_unit: directed checks followed by random traffic
// against a behavioural model of the register map and timer rules.
module tb_mmio_unit;

  localparam logic [1:0] CN = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  // Lit segments (active-high, {g,f,e,d,c,b,a}) for glyphs 0..F.
  localparam logic [6:0] LIT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = CN;
  logic [8:0]  mem_addr = '0;
  logic [15:0] wdata = '0;
  logic [7:0]  sw = '0;
  logic [15:0] rdata;
  logic        rvalid;
  logic [7:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        timer_flag;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Reference model state
  logic [7:0]  m_led;
  logic [15:0] m_hex;
  bit          m_en;
  int          m_cmp, m_cnt;
  bit          m_flag;
  logic [15:0] m_hold;
  logic [15:0] exp_q[$];

  mmio_unit dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .wdata(wdata), .sw(sw), .rdata(rdata), .rvalid(rvalid), .ledr(ledr),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .timer_flag(timer_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    return ~LIT[n];
  endfunction

  // Apply the register-map and timer rules for one clock edge.
  task automatic model_edge();
    int  v;
    bit  hit, match;
    if (reset) begin
      m_led = '0; m_hex = '0; m_en = 0; m_cmp = 0; m_cnt = 0; m_flag = 0;
      m_hold = '0;
      exp_q.delete();
      return;
    end
    match = m_en && (m_cmp != 0) && (m_cnt == m_cmp);
    if (mem_cmd == RD) begin
      hit = 1;
      v = 0;
      case (mem_addr)
        9'h100:  v = int'(m_led);
        9'h120:  v = int'(m_hex);
        9'h140:  v = int'(sw);
        9'h160:  v = int'(m_flag) * 2 + int'(m_en);
        9'h161:  v = m_cmp;
        9'h162:  v = m_cnt;
        default: hit = 0;
      endcase
      if (hit) begin
        exp_q.push_back(v[15:0]);
        m_hold = v[15:0];
      end
    end
    if (m_en && m_cmp != 0) m_cnt = match ? 0 : (m_cnt + 1) % 65536;
    if (match) m_flag = 1;
    if (mem_cmd == WR) begin
      case (mem_addr)
        9'h100: m_led = wdata[7:0];
        9'h120: m_hex = wdata;
        9'h160: begin
          m_en = wdata[0];
          if (wdata[1]) m_cnt = 0;
          if (wdata[2] && !match) m_flag = 0;
        end
        9'h161: m_cmp = int'(wdata);
        default: ;
      endcase
    end
  endtask

  task automatic do_cycle(input logic r, input logic [1:0] c,
                          input logic [8:0] a, input logic [15:0] d,
                          input logic [7:0] s);
    reset = r; mem_cmd = c; mem_addr = a; wdata = d; sw = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    logic [15:0] d;
    if (started) begin
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        check("rvalid_read", {31'b0, rvalid}, 32'd1);
        check("rdata_read", {16'b0, rdata}, {16'b0, d});
      end else begin
        check("rvalid_idle", {31'b0, rvalid}, 32'd0);
        check("rdata_hold", {16'b0, rdata}, {16'b0, m_hold});
      end
      check("ledr", {24'b0, ledr}, {24'b0, m_led});
      check("hex0", {25'b0, hex0}, {25'b0, glyph(m_hex[3:0])});
      check("hex1", {25'b0, hex1}, {25'b0, glyph(m_hex[7:4])});
      check("hex2", {25'b0, hex2}, {25'b0, glyph(m_hex[11:8])});
      check("hex3", {25'b0, hex3}, {25'b0, glyph(m_hex[15:12])});
      check("timer_flag", {31'b0, timer_flag}, {31'b0, m_flag});
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ledr"}, {24'b0, ledr}, 32'h0);
    check({tag, "_hex0"}, {25'b0, hex0}, 32'h40);
    check({tag, "_hex3"}, {25'b0, hex3}, 32'h40);
    check({tag, "_flag"}, {31'b0, timer_flag}, 32'h0);
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'h0);
    check({tag, "_rdata"}, {16'b0, rdata}, 32'h0);
  endtask

  initial begin
    logic [15:0] cnt_seq [5];
    logic [8:0]  addrs [6];
    logic [8:0]  a;
    logic [15:0] d;
    logic [1:0]  c;
    logic        r;
    cnt_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    addrs = '{9'h100, 9'h120, 9'h140, 9'h160, 9'h161, 9'h162};

    do_cycle(1, CN, 9'h0, 16'h0, 8'h0);
    do_cycle(1, RD, 9'h100, 16'h0, 8'h0);
    started = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // LED write then read-back
    do_cycle(0, WR, 9'h100, 16'h00A5, 8'h00);
    @(negedge clk);
    check("led_a5", {24'b0, ledr}, 32'hA5);
    do_cycle(0, RD, 9'h100, 16'h0, 8'h00);
    @(negedge clk);
    check("led_rd_valid", {31'b0, rvalid}, 32'h1);
    check("led_rd_data", {16'b0, rdata}, 32'h00A5);

    // Hex glyphs, then a write outside I/O space
    do_cycle(0, WR, 9'h120, 16'h1F3C, 8'h00);
    @(negedge clk);
    check("hex3_1", {25'b0, hex3}, 32'h79);
    check("hex2_f", {25'b0, hex2}, 32'h0E);
    check("hex1_3", {25'b0, hex1}, 32'h30);
    check("hex0_c", {25'b0, hex0}, 32'h46);
    do_cycle(0, WR, 9'h000, 16'hFFFF, 8'h00);
    @(negedge clk);
    check("mem_wr_led", {24'b0, ledr}, 32'hA5);
    check("mem_wr_hex0", {25'b0, hex0}, 32'h46);
    do_cycle(0, RD, 9'h000, 16'h0, 8'h00);
    @(negedge clk);
    check("mem_rd_rvalid", {31'b0, rvalid}, 32'h0);

    // Switch read, single-cycle rvalid, unmapped I/O read
    do_cycle(0, RD, 9'h140, 16'h0, 8'h5A);
    @(negedge clk);
    check("sw_rd_valid", {31'b0, rvalid}, 32'h1);
    check("sw_rd_data", {16'b0, rdata}, 32'h005A);
    do_cycle(0, CN, 9'h140, 16'h0, 8'h00);
    @(negedge clk);
    check("sw_rvalid_drop", {31'b0, rvalid}, 32'h0);
    do_cycle(0, RD, 9'h1FF, 16'h0, 8'h00);
    @(negedge clk);
    check("unmapped_rvalid", {31'b0, rvalid}, 32'h0);

    // Timer: cmp=3 gives 0,1,2,3,0 and the flag on the 3->0 edge
    do_cycle(0, WR, 9'h161, 16'd3, 8'h00);
    do_cycle(0, WR, 9'h160, 16'h0001, 8'h00);
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, RD, 9'h162, 16'h0, 8'h00);
      @(negedge clk);
      check("cnt_seq", {16'b0, rdata}, {16'b0, cnt_seq[i]});
      check("cnt_seq_flag", {31'b0, timer_flag}, (i >= 3) ? 32'd1 : 32'd0);
    end
    do_cycle(0, WR, 9'h160, 16'h0005, 8'h00);
    @(negedge clk);
    check("flag_cleared", {31'b0, timer_flag}, 32'h0);
    do_cycle(0, CN, 9'h0, 16'h0, 8'h00);
    do_cycle(0, RD, 9'h162, 16'h0, 8'h00);
    @(negedge clk);
    check("keeps_running", {16'b0, rdata}, 32'd3);

    // Flag clear on the match edge loses to the set
    do_cycle(0, WR, 9'h160, 16'h0006, 8'h00);
    do_cycle(0, WR, 9'h160, 16'h0006, 8'h00);
    do_cycle(0, WR, 9'h161, 16'd2, 8'h00);
    do_cycle(0, WR, 9'h160, 16'h0001, 8'h00);
    do_cycle(0, CN, 9'h0, 16'h0, 8'h00);
    do_cycle(0, CN, 9'h0, 16'h0, 8'h00);
    do_cycle(0, WR, 9'h160, 16'h0005, 8'h00);
    @(negedge clk);
    check("set_beats_clear", {31'b0, timer_flag}, 32'h1);
    do_cycle(0, RD, 9'h162, 16'h0, 8'h00);
    @(negedge clk);
    check("match_cnt_zero", {16'b0, rdata}, 32'd0);

    // Reset while running, with a read on the same edge
    do_cycle(1, RD, 9'h100, 16'h0, 8'h00);
    @(negedge clk);
    check_reset_state("midrun");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 249) == 0);
      case ($urandom_range(0, 9))
        0:       c = CN;
        1:       c = 2'b11;
        2, 3, 4: c = WR;
        default: c = RD;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 9'($urandom) : addrs[$urandom_range(0, 5)];
      d = 16'($urandom);
      if (a == 9'h160) begin
        d[0] = ($urandom_range(0, 9) != 0);
        d[1] = ($urandom_range(0, 7) == 0);
        d[2] = ($urandom_range(0, 3) == 0);
      end else if (a == 9'h161) begin
        d = 16'($urandom_range(0, 12));
      end
      do_cycle(r, c, a, d, 8'($urandom));
    end
    do_cycle(0, CN, 9'h0, 16'h0, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
